// File: rtl/nrs_qpsk_reader_if.sv
// nrs_qpsk_reader_if: c(n) memory read port plus QPSK NRS valid/ready stream
interface nrs_qpsk_reader_if #(
  parameter int LINES         = 4,
  parameter int NRS_WIDTH_R_I = 16
);
  logic                     c_n_ready;
  logic [LINES-1:0]         rd_addr;
  logic                     c_n;
  logic [NRS_WIDTH_R_I-1:0] nrs_r;
  logic [NRS_WIDTH_R_I-1:0] nrs_i;
  logic [2:0]               nrs_idx;
  logic                     nrs_valid;
  logic                     nrs_ready;
  logic                     sf_done;
  logic                     ovf;
  modport master (
    input  c_n_ready, c_n, nrs_ready,
    output rd_addr, nrs_r, nrs_i, nrs_idx, nrs_valid, sf_done, ovf
  );
  modport slave (
    output c_n_ready, c_n, nrs_ready,
    input  rd_addr, nrs_r, nrs_i, nrs_idx, nrs_valid, sf_done, ovf
  );
endinterface

// File: rtl/nrs_qpsk_reader.sv
// nrs_qpsk_reader: reads 16 c(n) bits in pairs and streams 8 QPSK NRS values per subframe
module nrs_qpsk_reader #(
  parameter int                              WIDTH_REG     = 16,
  parameter int                              LINES         = 4,
  parameter int                              NRS_WIDTH_R_I = 16,
  parameter logic signed [NRS_WIDTH_R_I-1:0] AMP           = 16'sd23170
) (
  input logic               clk,
  input logic               rst,
  nrs_qpsk_reader_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD_RE, RD_IM, OUT, DONE} state_t;
  state_t                   state_q, state_d;
  logic [LINES-2:0]         m_q, m_d;
  logic [LINES-1:0]         rd_addr_q, rd_addr_d;
  logic [NRS_WIDTH_R_I-1:0] nrs_r_q, nrs_r_d, nrs_i_q, nrs_i_d, cn_amp;
  logic                     valid_q, valid_d, first_q, first_d, sf_done_q, sf_done_d;
  logic                     pend_q, pend_d, ovf_q, ovf_d, start, busy;
  assign cn_amp = bus.c_n ? -AMP : AMP;
  assign start  = bus.c_n_ready | pend_q;
  assign busy   = state_q != IDLE;
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    rd_addr_d = rd_addr_q;
    nrs_r_d   = nrs_r_q;
    // imag bit is on c_n during the first OUT cycle; rd_addr holds so it stays there
    nrs_i_d   = first_q ? cn_amp : nrs_i_q;
    valid_d   = valid_q;
    first_d   = 1'b0;
    sf_done_d = 1'b0;
    pend_d    = pend_q | (bus.c_n_ready & busy);
    ovf_d     = ovf_q | (bus.c_n_ready & pend_q & busy & state_q != DONE);
    case (state_q)
      IDLE: if (start) begin
        state_d   = RD_RE;
        m_d       = '0;
        rd_addr_d = '0;
        pend_d    = 1'b0;
      end
      RD_RE: begin
        state_d   = RD_IM;
        rd_addr_d = {m_q, 1'b1};
      end
      RD_IM: begin
        state_d = OUT;
        nrs_r_d = cn_amp;
        valid_d = 1'b1;
        first_d = 1'b1;
      end
      OUT: if (valid_q && bus.nrs_ready) begin
        valid_d   = 1'b0;
        state_d   = &m_q ? DONE : RD_RE;
        sf_done_d = &m_q;
        m_d       = &m_q ? m_q : m_q + 1'b1;
        rd_addr_d = &m_q ? rd_addr_q : {m_q + 1'b1, 1'b0};
      end
      DONE: begin
        m_d       = '0;
        state_d   = start ? RD_RE : IDLE;
        rd_addr_d = start ? '0 : rd_addr_q;
        pend_d    = pend_q & bus.c_n_ready;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      rd_addr_q <= '0;
      nrs_r_q   <= '0;
      nrs_i_q   <= '0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      sf_done_q <= 1'b0;
      pend_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      rd_addr_q <= rd_addr_d;
      nrs_r_q   <= nrs_r_d;
      nrs_i_q   <= nrs_i_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
      sf_done_q <= sf_done_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
    end
  assign bus.rd_addr   = rd_addr_q;
  assign bus.nrs_r     = nrs_r_q;
  assign bus.nrs_i     = first_q ? cn_amp : nrs_i_q;
  assign bus.nrs_idx   = m_q;
  assign bus.nrs_valid = valid_q;
  assign bus.sf_done   = sf_done_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nrs_qpsk_reader.sv
// tb_nrs_qpsk_reader: directed checks of the c(n) pair reader with a 1-cycle-latency memory model
module tb_nrs_qpsk_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem;
  int          total = 0;
  int          bad = 0;
  nrs_qpsk_reader_if bus ();
  nrs_qpsk_reader dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) bus.c_n <= mem[bus.rd_addr];
  function automatic logic [15:0] amp(input logic b);
    return b ? 16'hA57E : 16'h5A82;
  endfunction
  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic test_reset;
    rst = 1'b0;
    bus.c_n_ready = 1'b0;
    bus.nrs_ready = 1'b1;
    mem = 16'h0000;
    #3 rst = 1'b1;
    #1;
    chk("reset_valid", {15'd0, bus.nrs_valid}, 16'd0);
    chk("reset_r", bus.nrs_r, 16'd0);
    chk("reset_i", bus.nrs_i, 16'd0);
    chk("reset_idx_addr", {9'd0, bus.nrs_idx, bus.rd_addr}, 16'd0);
    chk("reset_done_ovf", {14'd0, bus.sf_done, bus.ovf}, 16'd0);
    @(negedge clk) rst = 1'b0;
  endtask
  task automatic run_stream(input logic [15:0] v);
    int nv = 0;
    int first = -1;
    mem = v;
    @(negedge clk) bus.c_n_ready = 1'b1;
    for (int t = 1; t <= 27; t++) begin
      @(negedge clk) bus.c_n_ready = 1'b0;
      if (t % 3 == 1 && t <= 22) chk("rd_addr_re", {12'd0, bus.rd_addr}, 16'(2 * ((t - 1) / 3)));
      if (t % 3 == 2 && t <= 23) chk("rd_addr_im", {12'd0, bus.rd_addr}, 16'(2 * ((t - 2) / 3) + 1));
      if (bus.nrs_valid) begin
        if (first < 0) first = t;
        chk("idx", {13'd0, bus.nrs_idx}, 16'(nv));
        chk("nrs_r", bus.nrs_r, amp(v[2*nv]));
        chk("nrs_i", bus.nrs_i, amp(v[2*nv+1]));
        nv++;
      end
      chk("sf_done", {15'd0, bus.sf_done}, {15'd0, t == 25});
    end
    chk("first_valid_cycle", 16'(first), 16'd3);
    chk("pair_count", 16'(nv), 16'd8);
  endtask
  task automatic test_mapping;
    run_stream(16'h0000);
    run_stream(16'hAAAA);
    run_stream(16'hFFFF);
  endtask
  task automatic test_backpressure;
    int nv = 0;
    logic held = 1'b0;
    logic done = 1'b0;
    logic [15:0] r0, i0;
    mem = 16'h1234;
    @(negedge clk) bus.c_n_ready = 1'b1;
    for (int t = 1; t <= 40 && !done; t++) begin
      @(negedge clk) bus.c_n_ready = 1'b0;
      if (bus.nrs_valid) begin
        chk("bp_idx", {13'd0, bus.nrs_idx}, 16'(nv));
        chk("bp_r", bus.nrs_r, amp(mem[2*nv]));
        chk("bp_i", bus.nrs_i, amp(mem[2*nv+1]));
        if (nv == 3 && !held) begin
          held = 1'b1;
          bus.nrs_ready = 1'b0;
          r0 = bus.nrs_r;
          i0 = bus.nrs_i;
          for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", {15'd0, bus.nrs_valid}, 16'd1);
            chk("bp_hold_idx", {13'd0, bus.nrs_idx}, 16'd3);
            chk("bp_hold_r", bus.nrs_r, r0);
            chk("bp_hold_i", bus.nrs_i, i0);
            chk("bp_hold_addr", {12'd0, bus.rd_addr}, 16'd7);
          end
          bus.nrs_ready = 1'b1;
        end
        nv++;
      end
      if (bus.sf_done) done = 1'b1;
    end
    chk("bp_pairs", 16'(nv), 16'd8);
    chk("bp_sf_done", {15'd0, done}, 16'd1);
  endtask
  task automatic test_pending;
    int pulses = 1;
    int sf = 0;
    int dt = -1;
    int first2 = -1;
    logic extra = 1'b0;
    mem = 16'h0000;
    @(negedge clk) bus.c_n_ready = 1'b1;
    for (int t = 1; t <= 80 && sf < 2; t++) begin
      @(negedge clk) bus.c_n_ready = 1'b0;
      if (bus.nrs_valid && sf == 0 && bus.nrs_idx == 3'd2 && pulses == 1) begin
        bus.c_n_ready = 1'b1;
        pulses = 2;
      end
      if (bus.nrs_valid && sf == 0 && bus.nrs_idx == 3'd4 && pulses == 2) begin
        chk("ovf_before_third", {15'd0, bus.ovf}, 16'd0);
        bus.c_n_ready = 1'b1;
        pulses = 3;
      end
      if (bus.nrs_valid && sf == 0 && bus.nrs_idx == 3'd5) chk("ovf_after_third", {15'd0, bus.ovf}, 16'd1);
      if (bus.nrs_valid && sf == 1 && first2 < 0) begin
        first2 = t;
        chk("second_idx0", {13'd0, bus.nrs_idx}, 16'd0);
      end
      if (bus.sf_done) begin
        sf++;
        if (sf == 1) dt = t;
      end
    end
    chk("subframes", 16'(sf), 16'd2);
    chk("second_start", 16'(first2 - dt), 16'd3);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.nrs_valid) extra = 1'b1;
    end
    chk("no_third_subframe", {15'd0, extra}, 16'd0);
  endtask
  task automatic test_abort;
    logic seen = 1'b0;
    logic spur = 1'b0;
    mem = 16'hFFFF;
    @(negedge clk) bus.c_n_ready = 1'b1;
    for (int t = 1; t <= 30 && !seen; t++) begin
      @(negedge clk) bus.c_n_ready = 1'b0;
      if (bus.nrs_valid && bus.nrs_idx == 3'd5) seen = 1'b1;
    end
    chk("abort_reached_idx5", {15'd0, seen}, 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", {15'd0, bus.nrs_valid}, 16'd0);
    chk("abort_r", bus.nrs_r, 16'd0);
    chk("abort_i", bus.nrs_i, 16'd0);
    chk("abort_idx_addr", {9'd0, bus.nrs_idx, bus.rd_addr}, 16'd0);
    chk("abort_ovf_cleared", {15'd0, bus.ovf}, 16'd0);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.sf_done || bus.nrs_valid) spur = 1'b1;
    end
    chk("abort_silent", {15'd0, spur}, 16'd0);
    run_stream(16'h5A5A);
  endtask
  initial begin
    test_reset;
    test_mapping;
    test_backpressure;
    test_pending;
    test_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
